line_mem_responder: RTL and testbench

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

---
 rtl/line_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_line_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// line_mem_responder
//   Direct-mapped line store that answers line reads after a fixed latency.
//   Reads that miss (entry never written, or holding a different tag) return
//   a synthetic pattern derived from the requested address, so a reader can
//   always tell which line it received.
//
// Parameters
//   DELAY      : read latency in cycles (2..16); a read in cycle C is
//                answered in cycle C+DELAY.
//   INDEX_BITS : log2 of the number of lines; index = addr_in[INDEX_BITS+3:4].
//
// Ports
//   clk            : single clock, rising edge.
//   reset          : synchronous active-high reset.
//   addr_in[31:0]  : line address for reads and evictions (bits [3:0] ignored).
//   rden           : line read request, one per cycle, never stalled.
//   wren           : eviction write request, one per cycle, never stalled.
//   data_in[127:0] : eviction line, word k at [32k+31:32k].
//   data_out       : registered response line; holds between responses.
//   data_out_valid : one-cycle pulse qualifying data_out.
//   overlap_err    : sticky; a read was issued while another was in flight.
//   rd_count       : accepted reads, saturating at 16'hFFFF.
//   wr_count       : accepted writes, saturating at 16'hFFFF.
module line_mem_responder #(
  parameter int DELAY      = 5,
  parameter int INDEX_BITS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  addr_in,
  input  logic         rden,
  input  logic         wren,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         data_out_valid,
  output logic         overlap_err,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int NUM_LINES = 1 << INDEX_BITS;
  localparam int TAG_W     = 28;
  localparam int ENTRY_W   = TAG_W + 128;
  // Stages between the response mux and data_out.
  localparam int MID       = DELAY - 2;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag_in;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  unused_addr_bits;

  assign idx              = addr_in[INDEX_BITS+3:4];
  assign tag_in           = addr_in[31:4];
  assign unused_addr_bits = ^addr_in[3:0];
  // Requests during reset are dropped.
  assign rd_acc           = rden & ~reset;
  assign wr_acc           = wren & ~reset;

  // ---------------------------------------------------------------------
  // Backing store: tag and line share one RAM word. The registered read
  // sees the old word when a write hits the same entry in the same cycle,
  // which gives read-before-write for a simultaneous read and eviction.
  // Written bits live in flops so reset can clear them in one cycle.
  // ---------------------------------------------------------------------
  logic [ENTRY_W-1:0] line_mem [NUM_LINES];
  logic [ENTRY_W-1:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      line_mem[idx] <= {tag_in, data_in};
    end
    ram_rd_q <= line_mem[idx];
  end

  logic [NUM_LINES-1:0] written_q, written_d;
  logic                 s1_written_q, s1_written_d;
  logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;
  logic [DELAY-2:0]     vld_q, vld_d;
  logic                 overlap_q, overlap_d;
  logic [15:0]          rd_count_q, rd_count_d;
  logic [15:0]          wr_count_q, wr_count_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [127:0]         dout_q, dout_d;

  // ---------------------------------------------------------------------
  // Response formation, one cycle after the request: hit only when the
  // entry was written and its tag matches the requested line.
  // ---------------------------------------------------------------------
  logic [127:0] pattern;
  logic [127:0] resp;
  logic         hit;
  logic [127:0] line_src;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pattern
    assign pattern[32*gi +: 32] = {s1_tag_q, 2'(gi), 2'b00};
  end

  assign hit  = s1_written_q && (ram_rd_q[ENTRY_W-1:128] == s1_tag_q);
  assign resp = hit ? ram_rd_q[127:0] : pattern;

  // Pure data shift; only the valid bits need reset because data_out
  // loads solely when a valid bit reaches the end.
  if (MID > 0) begin : g_mid
    logic [127:0] mid_q [MID];

    always_ff @(posedge clk) begin
      for (int i = MID - 1; i > 0; i--) begin
        mid_q[i] <= mid_q[i-1];
      end
      mid_q[0] <= resp;
    end

    assign line_src = mid_q[MID-1];
  end else begin : g_no_mid
    assign line_src = resp;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    written_d    = written_q;
    s1_written_d = written_q[idx];
    s1_tag_d     = tag_in;
    vld_d        = '0;
    overlap_d    = overlap_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    dout_valid_d = vld_q[DELAY-2];
    dout_d       = dout_q;

    if (wr_acc) begin
      written_d[idx] = 1'b1;
    end

    vld_d[0] = rd_acc;
    for (int i = 1; i < DELAY - 1; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    // vld_q holds exactly the reads issued in the last DELAY-1 cycles
    // that have not yet reached data_out.
    if (rd_acc && (|vld_q)) begin
      overlap_d = 1'b1;
    end

    if (rd_acc && (rd_count_q != 16'hFFFF)) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (wr_acc && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end

    if (dout_valid_d) begin
      dout_d = line_src;
    end

    if (reset) begin
      written_d    = '0;
      vld_d        = '0;
      overlap_d    = 1'b0;
      rd_count_d   = '0;
      wr_count_d   = '0;
      dout_valid_d = 1'b0;
      dout_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    written_q    <= written_d;
    s1_written_q <= s1_written_d;
    s1_tag_q     <= s1_tag_d;
    vld_q        <= vld_d;
    overlap_q    <= overlap_d;
    rd_count_q   <= rd_count_d;
    wr_count_q   <= wr_count_d;
    dout_valid_q <= dout_valid_d;
    dout_q       <= dout_d;
  end

  assign data_out       = dout_q;
  assign data_out_valid = dout_valid_q;
  assign overlap_err    = overlap_q;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Testbench for line_mem_responder (DELAY=5, INDEX_BITS=8).
// A cycle-indexed model predicts every output each cycle; directed
// transactions also carry hand-written literal expectations.
module tb_line_mem_responder;

  localparam int DELAY = 5;
  localparam int IB    = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr_in;
  logic         rden;
  logic         wren;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         data_out_valid;
  logic         overlap_err;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;

  always #5 clk = ~clk;

  line_mem_responder #(.DELAY(DELAY), .INDEX_BITS(IB)) dut (
    .clk           (clk),
    .reset         (reset),
    .addr_in       (addr_in),
    .rden          (rden),
    .wren          (wren),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .overlap_err   (overlap_err),
    .rd_count      (rd_count),
    .wr_count      (wr_count)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ------------------------------------------------------------------
  // Model: a memory of (line, tag, written) plus a list of responses
  // scheduled for future cycles.
  // ------------------------------------------------------------------
  typedef struct {
    int           due;
    logic [127:0] line;
  } resp_t;

  logic [127:0] m_data [1 << IB];
  logic [27:0]  m_tag  [1 << IB];
  bit           m_wr   [1 << IB];
  resp_t        exp_q[$];
  logic [127:0] m_last = '0;
  bit           m_err  = 1'b0;
  logic [15:0]  m_rd   = '0;
  logic [15:0]  m_wrc  = '0;
  bit           model_on = 1'b0;

  function automatic logic [127:0] pattern(input logic [31:0] a);
    logic [127:0] p;
    for (int k = 0; k < 4; k++) begin
      p[32*k +: 32] = {a[31:4], 4'b0000} + 32'(4 * k);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] a);
    int i;
    i = int'(a[IB+3:4]);
    if (m_wr[i] && m_tag[i] == a[31:4]) return m_data[i];
    return pattern(a);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < (1 << IB); i++) m_wr[i] = 1'b0;
      exp_q.delete();
      m_last   = '0;
      m_err    = 1'b0;
      m_rd     = '0;
      m_wrc    = '0;
      model_on = 1'b1;
    end else begin
      if (rden) begin
        foreach (exp_q[j]) if (exp_q[j].due > cyc) m_err = 1'b1;
        exp_q.push_back('{due: cyc + DELAY, line: model_line(addr_in)});
        if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
      end
      if (wren) begin
        m_data[int'(addr_in[IB+3:4])] = data_in;
        m_tag[int'(addr_in[IB+3:4])]  = addr_in[31:4];
        m_wr[int'(addr_in[IB+3:4])]   = 1'b1;
        if (m_wrc != 16'hFFFF) m_wrc = m_wrc + 16'd1;
      end
    end
    cyc = cyc + 1;
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (model_on) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("m_valid", 128'(data_out_valid), 128'd1);
        chk("m_data", data_out, exp_q[0].line);
        m_last = exp_q[0].line;
        void'(exp_q.pop_front());
      end else begin
        chk("m_valid", 128'(data_out_valid), 128'd0);
        chk("m_hold", data_out, m_last);
      end
      chk("m_overlap", 128'(overlap_err), 128'(m_err));
      chk("m_rd_count", 128'(rd_count), 128'(m_rd));
      chk("m_wr_count", 128'(wr_count), 128'(m_wrc));
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [127:0] d);
    rden    = r;
    wren    = w;
    addr_in = a;
    data_in = d;
    tick();
    rden = 1'b0;
    wren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic lit(input string name, input logic [127:0] exp);
    @(negedge clk);
    chk({name, "_valid"}, 128'(data_out_valid), 128'd1);
    chk(name, data_out, exp);
  endtask

  localparam logic [127:0] D1    = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] D2    = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D3    = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] P1230 = 128'h0000123C_00001238_00001234_00001230;
  localparam logic [127:0] P2230 = 128'h0000223C_00002238_00002234_00002230;
  localparam logic [127:0] P0040 = 128'h0000004C_00000048_00000044_00000040;

  initial begin
    reset   = 1'b1;
    rden    = 1'b0;
    wren    = 1'b0;
    addr_in = '0;
    data_in = '0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 128'(data_out_valid), 128'd0);
    chk("rst_data", data_out, 128'd0);
    chk("rst_overlap", 128'(overlap_err), 128'd0);
    chk("rst_rd_count", 128'(rd_count), 128'd0);
    chk("rst_wr_count", 128'(wr_count), 128'd0);
    $display("reset released at cycle %0d", cyc);

    // Unwritten read returns the address pattern.
    req(1'b1, 1'b0, 32'h0000_1230, '0);
    idle(4);
    lit("unwritten", P1230);
    $display("read 0x1230 unwritten -> %h", data_out);

    // Fresh counters, then write followed by read.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req(1'b0, 1'b1, 32'h0000_1230, D1);
    req(1'b1, 1'b0, 32'h0000_1230, '0);
    idle(4);
    lit("wr_then_rd", D1);
    chk("wr_count_1", 128'(wr_count), 128'd1);
    chk("rd_count_1", 128'(rd_count), 128'd1);
    $display("write/read 0x1230 -> %h", data_out);

    // Aliasing index: different tag misses, eviction displaces old line.
    req(1'b1, 1'b0, 32'h0000_2230, '0);
    idle(4);
    lit("alias_rd", P2230);
    $display("read 0x2230 alias -> %h", data_out);
    req(1'b0, 1'b1, 32'h0000_2230, D2);
    req(1'b1, 1'b0, 32'h0000_1230, '0);
    idle(4);
    lit("alias_evicted", P1230);
    $display("read 0x1230 after evict -> %h", data_out);

    // Same-cycle read and write: read sees pre-write contents.
    req(1'b1, 1'b1, 32'h0000_0040, D3);
    idle(4);
    lit("rw_same_cycle", P0040);
    $display("read+write 0x40 -> %h", data_out);
    req(1'b1, 1'b0, 32'h0000_0040, '0);
    idle(4);
    lit("rw_followup", D3);
    chk("no_overlap_yet", 128'(overlap_err), 128'd0);
    $display("read 0x40 after write -> %h", data_out);

    // Back-to-back reads.
    req(1'b1, 1'b0, 32'h0000_1230, '0);
    req(1'b1, 1'b0, 32'h0000_0040, '0);
    @(negedge clk);
    chk("overlap_set", 128'(overlap_err), 128'd1);
    idle(3);
    lit("b2b_first", P1230);
    idle(1);
    lit("b2b_second", D3);
    $display("back-to-back reads -> %h then %h", P1230, data_out);

    // Reset with a read in flight.
    req(1'b1, 1'b0, 32'h0000_0040, '0);
    idle(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 128'(data_out_valid), 128'd0);
    chk("mid_rst_data", data_out, 128'd0);
    chk("mid_rst_overlap", 128'(overlap_err), 128'd0);
    chk("mid_rst_rd_count", 128'(rd_count), 128'd0);
    chk("mid_rst_wr_count", 128'(wr_count), 128'd0);
    for (int k = 4; k <= 10; k++) begin
      tick();
      @(negedge clk);
      chk("flushed_quiet", 128'(data_out_valid), 128'd0);
    end
    req(1'b1, 1'b0, 32'h0000_0040, '0);
    idle(4);
    lit("post_reset_rd", P0040);
    $display("read 0x40 after reset -> %h", data_out);

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
